// File: rtl/avs_pkg.sv
// Shared types and default voltage limits for the adaptive-voltage-scaling loop.
// The regulator model uses the same VMIN/VMAX/VINIT defaults.
package avs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_DECIDE,
      ST_REQUEST,
      ST_SETTLE
   } state_t;

   typedef enum logic [1:0] {
      STEP_UP,
      STEP_DOWN,
      HOLD
   } decision_t;

   localparam logic [7:0] AVS_VMIN  = 8'd16;
   localparam logic [7:0] AVS_VMAX  = 8'd240;
   localparam logic [7:0] AVS_VINIT = 8'd128;

endpackage

// File: rtl/avs_timer.sv
// Loadable down-counter with a terminal-count flag.
// The controller uses it for both the settle interval and the ack timeout.
module avs_timer #(
   parameter int W = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         tc
);

   logic [W-1:0] count_q;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/avs_step_controller.sv
// Closed-loop AVS controller: samples the smoothed slack code, compares it with
// a hold window and issues single-LSB voltage steps over a req/ack handshake.
module avs_step_controller
   import avs_pkg::*;
#(
   parameter int               BUS         = 6,
   parameter int               VBITS       = 8,
   parameter logic [VBITS-1:0] VMIN        = VBITS'(AVS_VMIN),
   parameter logic [VBITS-1:0] VMAX        = VBITS'(AVS_VMAX),
   parameter logic [VBITS-1:0] VINIT       = VBITS'(AVS_VINIT),
   parameter int               SETTLE      = 16,
   parameter int               ACK_TIMEOUT = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [BUS-1:0]   sensor_code,
   input  logic [BUS-1:0]   target_lo,
   input  logic [BUS-1:0]   target_hi,
   output logic             vreq,
   output logic             vup,
   input  logic             vack,
   output logic [VBITS-1:0] vcode,
   output logic             busy,
   output logic             at_limit,
   output logic             fault
);

   localparam int TMAX = (SETTLE > ACK_TIMEOUT) ? SETTLE : ACK_TIMEOUT;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   state_t      state_q, state_d;
   decision_t   decision;
   logic        step_blocked;
   logic [BUS-1:0] code_q;
   logic        timer_load;
   logic [TW-1:0] timer_value;
   logic        timer_tc;

   avs_timer #(.W(TW)) u_timer (
      .clock (clock),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .tc    (timer_tc)
   );

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      decision    = HOLD;
      timer_load  = 1'b0;
      timer_value = '0;

      if (code_q < target_lo) begin
         decision = STEP_UP;
      end else if (code_q > target_hi) begin
         decision = STEP_DOWN;
      end
      step_blocked = ((decision == STEP_UP)   && (vcode >= VMAX)) ||
                     ((decision == STEP_DOWN) && (vcode <= VMIN));

      case (state_q)
         ST_IDLE: begin
            if (enable && !fault) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            state_d = enable ? ST_DECIDE : ST_IDLE;
         end
         ST_DECIDE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if ((decision != HOLD) && !step_blocked) begin
               state_d     = ST_REQUEST;
               timer_load  = 1'b1;
               timer_value = TW'(ACK_TIMEOUT - 1);
            end else begin
               state_d     = ST_SETTLE;
               timer_load  = 1'b1;
               timer_value = TW'(SETTLE - 1);
            end
         end
         // A request always finishes by ack or timeout, whatever enable does.
         ST_REQUEST: begin
            if (vack) begin
               state_d     = ST_SETTLE;
               timer_load  = 1'b1;
               timer_value = TW'(SETTLE - 1);
            end else if (timer_tc) begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!enable || fault) begin
               state_d = ST_IDLE;
            end else if (timer_tc) begin
               state_d = ST_SAMPLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         code_q   <= '0;
         vcode    <= VINIT;
         vreq     <= 1'b0;
         vup      <= 1'b0;
         busy     <= 1'b0;
         at_limit <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state_q <= state_d;
         vreq    <= (state_d == ST_REQUEST);
         busy    <= (state_d != ST_IDLE);

         if (state_q == ST_SAMPLE) code_q <= sensor_code;

         if (state_q == ST_DECIDE) begin
            at_limit <= step_blocked;
            if (state_d == ST_REQUEST) vup <= (decision == STEP_UP);
         end

         // Limits were checked in DECIDE, so the step cannot leave [VMIN, VMAX].
         if (state_q == ST_REQUEST) begin
            if (vack) begin
               vcode <= vup ? vcode + 1'b1 : vcode - 1'b1;
            end else if (timer_tc) begin
               fault <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_avs_step_controller.sv
// Directed bench for avs_step_controller: window hold, up-stepping to VMAX,
// down-step to VMIN, ack timeout, enable drop mid-request, async reset.
module tb_avs_step_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [5:0] sensor_code = '0;
   logic [5:0] target_lo = 6'd20;
   logic [5:0] target_hi = 6'd40;
   logic       vack = 1'b0;
   logic       vack_lo = 1'b0;
   logic       vreq, vup, busy, at_limit, fault;
   logic [7:0] vcode;
   logic       vreq_lo, vup_lo, busy_lo, at_limit_lo, fault_lo;
   logic [7:0] vcode_lo;

   int vectors = 0;
   int miscompares = 0;
   logic auto_ack = 1'b0;
   int ack_delay = 2;
   int ack_cnt = 0;
   int ack_cnt_lo = 0;

   always #5 clock = ~clock;

   avs_step_controller dut (
      .clock(clock), .reset(reset), .enable(enable), .sensor_code(sensor_code),
      .target_lo(target_lo), .target_hi(target_hi), .vreq(vreq), .vup(vup),
      .vack(vack), .vcode(vcode), .busy(busy), .at_limit(at_limit), .fault(fault)
   );

   avs_step_controller #(.VINIT(8'd17)) dut_lo (
      .clock(clock), .reset(reset), .enable(enable), .sensor_code(sensor_code),
      .target_lo(target_lo), .target_hi(target_hi), .vreq(vreq_lo), .vup(vup_lo),
      .vack(vack_lo), .vcode(vcode_lo), .busy(busy_lo), .at_limit(at_limit_lo),
      .fault(fault_lo)
   );

   // Regulator stand-in: raises a level ack ack_delay negedges after vreq rises.
   always @(negedge clock) begin
      if (auto_ack && vreq) begin
         ack_cnt = ack_cnt + 1;
         vack = (ack_cnt >= ack_delay);
      end else begin
         ack_cnt = 0;
         vack = 1'b0;
      end
      if (auto_ack && vreq_lo) begin
         ack_cnt_lo = ack_cnt_lo + 1;
         vack_lo = (ack_cnt_lo >= ack_delay);
      end else begin
         ack_cnt_lo = 0;
         vack_lo = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Hold reset 3 cycles, then release at a negedge with the given stimulus.
   task automatic restart(input logic [5:0] code, input logic en);
      @(negedge clock);
      reset = 1'b0;
      enable = 1'b0;
      tick(3);
      sensor_code = code;
      enable = en;
      reset = 1'b1;
   endtask

   initial begin
      int seen;
      int high;

      // 1: in-window code, no requests
      restart(6'd30, 1'b1);
      check("rst_vcode", 32'(vcode), 32'd128);
      check("rst_vreq", 32'(vreq), 32'd0);
      check("rst_vup", 32'(vup), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_at_limit", 32'(at_limit), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (vreq) seen++;
      end
      check("win_no_vreq", 32'(seen), 32'd0);
      check("win_vcode", 32'(vcode), 32'd128);
      check("win_busy", 32'(busy), 32'd1);
      check("win_at_limit", 32'(at_limit), 32'd0);

      // 2: low slack steps up to VMAX
      auto_ack = 1'b1;
      ack_delay = 2;
      restart(6'd10, 1'b1);
      tick(2);
      check("up_vreq_early", 32'(vreq), 32'd0);
      tick(1);
      check("up_vreq_rise", 32'(vreq), 32'd1);
      check("up_vup", 32'(vup), 32'd1);
      tick(2);
      check("up_vcode_129", 32'(vcode), 32'd129);
      check("up_vreq_drop", 32'(vreq), 32'd0);
      tick(17);
      check("up_settle_wait", 32'(vreq), 32'd0);
      tick(1);
      check("up_second_vreq", 32'(vreq), 32'd1);
      for (int i = 0; i < 4000 && vcode != 8'd240; i++) tick(1);
      check("up_reach_vmax", 32'(vcode), 32'd240);
      tick(20);
      check("up_at_limit", 32'(at_limit), 32'd1);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (vreq) seen++;
      end
      check("up_no_vreq_at_max", 32'(seen), 32'd0);
      check("up_vcode_held", 32'(vcode), 32'd240);

      // 3: high slack on the VINIT=17 instance steps to VMIN once
      restart(6'd50, 1'b1);
      check("lo_rst_at_limit", 32'(at_limit), 32'd0);
      check("lo_rst_vcode", 32'(vcode_lo), 32'd17);
      tick(3);
      check("lo_vreq", 32'(vreq_lo), 32'd1);
      check("lo_vup", 32'(vup_lo), 32'd0);
      tick(2);
      check("lo_vcode_16", 32'(vcode_lo), 32'd16);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (vreq_lo) seen++;
      end
      check("lo_no_vreq_at_min", 32'(seen), 32'd0);
      check("lo_at_limit", 32'(at_limit_lo), 32'd1);
      check("lo_vcode_held", 32'(vcode_lo), 32'd16);

      // 4: no ack -> timeout after exactly 64 cycles of vreq
      auto_ack = 1'b0;
      restart(6'd10, 1'b1);
      tick(3);
      high = 0;
      for (int i = 0; i < 200 && vreq; i++) begin
         high++;
         tick(1);
      end
      check("to_vreq_cycles", 32'(high), 32'd64);
      check("to_fault", 32'(fault), 32'd1);
      check("to_vreq_low", 32'(vreq), 32'd0);
      check("to_vcode", 32'(vcode), 32'd128);
      check("to_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      tick(2);
      enable = 1'b1;
      tick(10);
      check("to_no_restart_busy", 32'(busy), 32'd0);
      check("to_no_restart_vreq", 32'(vreq), 32'd0);
      check("to_fault_sticky", 32'(fault), 32'd1);
      reset = 1'b0;
      #1;
      check("to_fault_cleared", 32'(fault), 32'd0);

      // 5: enable drops during the request; handshake still completes
      auto_ack = 1'b1;
      ack_delay = 5;
      restart(6'd10, 1'b1);
      tick(3);
      check("en_vreq_rise", 32'(vreq), 32'd1);
      tick(1);
      enable = 1'b0;
      tick(2);
      check("en_vreq_held", 32'(vreq), 32'd1);
      tick(2);
      check("en_vcode_129", 32'(vcode), 32'd129);
      check("en_vreq_drop", 32'(vreq), 32'd0);
      tick(1);
      check("en_idle_busy", 32'(busy), 32'd0);
      tick(20);
      check("en_idle_vreq", 32'(vreq), 32'd0);
      check("en_idle_vcode", 32'(vcode), 32'd129);

      // 6: async reset while a request is pending
      ack_delay = 2;
      restart(6'd10, 1'b1);
      tick(5);
      check("ar_first_step", 32'(vcode), 32'd129);
      tick(18);
      check("ar_vreq_high", 32'(vreq), 32'd1);
      reset = 1'b0;
      #1;
      check("ar_vreq_async", 32'(vreq), 32'd0);
      check("ar_vcode_async", 32'(vcode), 32'd128);
      check("ar_busy_async", 32'(busy), 32'd0);
      auto_ack = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/avs_step_controller.md
Name: avs_step_controller

Overview:
Closed-loop adaptive-voltage-scaling controller. It samples the de-glitched delay-sensor code produced by the sensor smoother and compares it against a programmable slack window. It then issues single-LSB voltage step requests to the regulator interface over a req/ack handshake, with a settle interval between decisions. It sits between the smoother output and the regulator model and owns the current voltage code.

Parameters:
BUS, 6, sensor code width (matches smoother bus)
VBITS, 8, voltage code width
VMIN, 8'd16, lowest permitted voltage code
VMAX, 8'd240, highest permitted voltage code
VINIT, 8'd128, voltage code loaded at reset
SETTLE, 16, cycles waited after each decision before the next sample (>=1)
ACK_TIMEOUT, 64, max cycles vreq may stay high without vack

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  loop enable
sensor_code  input  BUS  smoothed slack code (higher = more timing slack)
target_lo  input  BUS  lower bound of the hold window
target_hi  input  BUS  upper bound of the hold window
vreq  output  1  step request to regulator
vup  output  1  step direction: 1 = +1 LSB, 0 = -1 LSB; valid while vreq=1
vack  input  1  regulator accepted the step (single-cycle or level)
vcode  output  VBITS  current committed voltage code
busy  output  1  high in any state other than IDLE
at_limit  output  1  last decision wanted a step blocked by VMIN/VMAX
fault  output  1  sticky ack-timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, vcode=VINIT, vreq=0, vup=0, busy=0, at_limit=0, fault=0, all counters=0. All outputs are registered.
- States: IDLE, SAMPLE, DECIDE, REQUEST, SETTLE.
- IDLE: if enable=1 and fault=0, go to SAMPLE. Otherwise stay in IDLE.
- SAMPLE (1 cycle): register sensor_code into code_q, then go to DECIDE.
- DECIDE (1 cycle), evaluated as unsigned compares in this priority order:
  - code_q < target_lo: if vcode < VMAX, set vup=1 and go to REQUEST; otherwise set at_limit=1 and go to SETTLE.
  - else code_q > target_hi: if vcode > VMIN, set vup=0 and go to REQUEST; otherwise set at_limit=1 and go to SETTLE.
  - else (in window): go to SETTLE.
  - at_limit is updated on every DECIDE: set when a step is blocked, cleared otherwise.
  - target_lo > target_hi is not checked; the priority order above resolves it.
- REQUEST:
  - vreq=1 for the whole state; vup is held stable.
  - When vack=1 is sampled: vcode <= vcode+1 if vup, else vcode-1; vreq drops the next cycle; go to SETTLE.
  - Timeout counter starts at 0 on entry. If ACK_TIMEOUT cycles pass with no vack: fault=1, vreq=0, vcode unchanged, go to IDLE.
- SETTLE: count SETTLE cycles. At terminal count, go to SAMPLE if enable=1 and fault=0, else to IDLE.
- Latency:
  - A decision is made 2 cycles after leaving IDLE/SETTLE; vreq rises on the cycle after DECIDE.
  - A full step cycle is 3 + ack-wait + SETTLE cycles.
- enable falls mid-operation:
  - In REQUEST, the handshake always completes (ack or timeout); a request is never abandoned.
  - In SAMPLE, DECIDE or SETTLE, go to IDLE on the next edge.
- vcode never leaves [VMIN, VMAX], and no wrap-around is possible.
- vack while not in REQUEST is ignored.
- fault is cleared only by reset.
- Reset mid-REQUEST drops vreq asynchronously and restores vcode=VINIT.

Decomposition:
- Shared package avs_pkg holds:
  - the state enum (IDLE, SAMPLE, DECIDE, REQUEST, SETTLE);
  - the decision enum (STEP_UP, STEP_DOWN, HOLD);
  - the default VMIN/VMAX/VINIT constants, shared with the regulator model.
- One sub-module, avs_timer: a loadable down-counter with terminal-count output. It is used for both the SETTLE and ACK_TIMEOUT counts, with width set by $clog2 of the larger value.

Test Plan:
1. Hold low 3 cycles, then release with enable=1, target_lo=20, target_hi=40, sensor_code=30 -> vcode stays 128, vreq never asserts, busy=1, at_limit=0.
2. sensor_code=10, vack returned 2 cycles after vreq -> vreq rises 3 cycles after enable, vup=1, vcode=129 after ack. Next step follows SETTLE=16 cycles later. Repeating with code held at 10 reaches 240 and then sets at_limit=1 with no further vreq.
3. sensor_code=50 with VINIT forced near the floor (VINIT=17) -> one down-step to 16, then at_limit=1 and no further requests.
4. vack tied 0 -> vreq is high exactly 64 cycles, then fault=1, vreq=0, vcode=128, state IDLE. Toggling enable does not restart; only reset clears fault.
5. enable dropped 1 cycle after vreq rises, vack at +5 -> vcode still commits to 129, then the controller goes to IDLE with busy=0.
6. reset asserted while vreq=1 -> vreq=0 immediately (before the next clock edge) and vcode=128.
